soc_dma_master: RTL and testbench



---
 rtl/soc_dma_master_pkg.sv | 21 ++
 rtl/soc_dma_master_if.sv | 22 ++
 rtl/soc_dma_master_bus_adapter.sv | 21 ++
 rtl/soc_dma_master.sv | 193 +++++++++++++++++++
 tb/tb_soc_dma_master.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_dma_master_pkg.sv
// Shared DMA types and SoC integration constants.
package globalconf;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } dma_state_t;

    localparam int unsigned DMA_TIMEOUT_CYCLES = 255;
    localparam int unsigned DMA_LEN_WIDTH      = 16;

    // Register map offsets of the DMA block in the SoC peripheral space.
    localparam logic [31:0] ADDR_DMA_SRC    = 32'h0000_0000;
    localparam logic [31:0] ADDR_DMA_DST    = 32'h0000_0004;
    localparam logic [31:0] ADDR_DMA_LEN    = 32'h0000_0008;
    localparam logic [31:0] ADDR_DMA_CTRL   = 32'h0000_000C;
    localparam logic [31:0] ADDR_DMA_STATUS = 32'h0000_0010;

endpackage

// File: rtl/soc_dma_master_if.sv
// SoC memory interconnect port: one request/ready handshake per word.
interface SoC_MemBus;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport Master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport Slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/soc_dma_master_bus_adapter.sv
// Maps the DMA engine's flat bus signals onto the interconnect master port.
module soc_dma_bus_adapter (
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    SoC_MemBus.Master   bus
);

    // Pure wiring; full-word accesses only, so byte enables are constant.
    assign bus.mem_req   = i_req;
    assign bus.mem_addr  = i_addr;
    assign bus.mem_we    = i_we;
    assign bus.mem_be    = 4'b1111;
    assign bus.mem_wdata = i_wdata;
    assign o_ready       = bus.mem_ready;
    assign o_rdata       = bus.mem_rdata;

endmodule

// File: rtl/soc_dma_master.sv
// Single-channel word copy engine: one read then one write per word.
module soc_dma_master
    import globalconf::*;
#(
    parameter int unsigned LEN_WIDTH      = DMA_LEN_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DMA_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 resn,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_length,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [LEN_WIDTH-1:0] o_words_done,
    SoC_MemBus.Master            bus
);

    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    dma_state_t           r_state,      w_state_nxt;
    logic [31:0]          r_src,        w_src_nxt;
    logic [31:0]          r_dst,        w_dst_nxt;
    logic [LEN_WIDTH-1:0] r_length,     w_length_nxt;
    logic [LEN_WIDTH-1:0] r_words_done, w_words_done_nxt;
    logic [TCNT_W-1:0]    r_tcnt,       w_tcnt_nxt;
    logic                 r_error,      w_error_nxt;
    logic                 r_done,       w_done_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic                 r_mem_req,    w_mem_req_nxt;
    logic [31:0]          r_mem_addr,   w_mem_addr_nxt;
    logic                 r_mem_we,     w_mem_we_nxt;
    logic [31:0]          r_mem_wdata,  w_mem_wdata_nxt;

    logic                 w_mem_ready;
    logic [31:0]          w_mem_rdata;
    logic                 w_timeout;
    logic                 w_last_word;
    logic                 w_misaligned;

    assign w_timeout    = (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign w_last_word  = ((r_words_done + LEN_WIDTH'(1)) == r_length);
    assign w_misaligned = (i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resn) begin
            r_state      <= IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_length     <= '0;
            r_words_done <= '0;
            r_tcnt       <= '0;
            r_error      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_src        <= w_src_nxt;
            r_dst        <= w_dst_nxt;
            r_length     <= w_length_nxt;
            r_words_done <= w_words_done_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_error      <= w_error_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    // Next-state and next-output logic; bus fields only move on ready or timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_src_nxt        = r_src;
        w_dst_nxt        = r_dst;
        w_length_nxt     = r_length;
        w_words_done_nxt = r_words_done;
        w_tcnt_nxt       = r_tcnt;
        w_error_nxt      = r_error;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_we_nxt     = r_mem_we;
        w_mem_wdata_nxt  = r_mem_wdata;

        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_src_nxt        = i_src_addr;
                    w_dst_nxt        = i_dst_addr;
                    w_length_nxt     = i_length;
                    w_words_done_nxt = '0;
                    w_error_nxt      = 1'b0;
                    if (i_length == '0) begin
                        w_state_nxt = FINISH;
                    end else if (w_misaligned) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt    = READ;
                        w_mem_req_nxt  = 1'b1;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = i_src_addr;
                        w_tcnt_nxt     = '0;
                    end
                end
            end
            READ: begin
                if (w_mem_ready) begin
                    w_mem_wdata_nxt = w_mem_rdata;
                    w_src_nxt       = r_src + 32'd4;
                    if (i_abort) begin
                        w_error_nxt   = 1'b1;
                        w_mem_req_nxt = 1'b0;
                        w_state_nxt   = FINISH;
                    end else begin
                        w_state_nxt    = WRITE;
                        w_mem_we_nxt   = 1'b1;
                        w_mem_addr_nxt = r_dst;
                        w_tcnt_nxt     = '0;
                    end
                end else if (w_timeout) begin
                    w_error_nxt   = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = FINISH;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            WRITE: begin
                if (w_mem_ready) begin
                    w_dst_nxt        = r_dst + 32'd4;
                    w_words_done_nxt = r_words_done + LEN_WIDTH'(1);
                    if (w_last_word) begin
                        w_mem_req_nxt = 1'b0;
                        w_state_nxt   = FINISH;
                    end else if (i_abort) begin
                        w_error_nxt   = 1'b1;
                        w_mem_req_nxt = 1'b0;
                        w_state_nxt   = FINISH;
                    end else begin
                        w_state_nxt    = READ;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = r_src;
                        w_tcnt_nxt     = '0;
                    end
                end else if (w_timeout) begin
                    w_error_nxt   = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = FINISH;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase

        w_done_nxt = (w_state_nxt == FINISH);
        w_busy_nxt = (w_state_nxt == READ) || (w_state_nxt == WRITE);
    end

    // Interconnect-facing wiring lives only in the adapter.
    soc_dma_bus_adapter u_bus_adapter (
        .i_req   (r_mem_req),
        .i_addr  (r_mem_addr),
        .i_we    (r_mem_we),
        .i_wdata (r_mem_wdata),
        .o_ready (w_mem_ready),
        .o_rdata (w_mem_rdata),
        .bus     (bus)
    );

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_words_done = r_words_done;

endmodule

// File: tb/tb_soc_dma_master.sv
// Directed bench for soc_dma_master with a latency-programmable slave and a transaction scoreboard.
module tb_soc_dma_master;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        resn;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_src_addr;
    logic [31:0] i_dst_addr;
    logic [15:0] i_length;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_words_done;

    SoC_MemBus bus_if ();

    soc_dma_master #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .resn         (resn),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_src_addr   (i_src_addr),
        .i_dst_addr   (i_dst_addr),
        .i_length     (i_length),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_words_done (o_words_done),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    // Source memory contents are a fixed function of the word address.
    function automatic logic [31:0] src_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Slave: ready after sl_lat wait cycles of a held request.
    int sl_lat = 0;
    int sl_cnt = 0;
    assign bus_if.mem_ready = bus_if.mem_req && (sl_cnt == sl_lat);
    assign bus_if.mem_rdata = src_word(bus_if.mem_addr);

    always @(posedge clk) begin
        if (bus_if.mem_req && !bus_if.mem_ready) sl_cnt <= sl_cnt + 1;
        else                                     sl_cnt <= 0;
    end

    // Monitor: completed transactions, request cycles, done pulses, held-request stability.
    txn_t log_q[$];
    int   req_cnt      = 0;
    int   done_cnt     = 0;
    int   unstable_cnt = 0;
    logic hold_prev    = 1'b0;
    txn_t prev_txn;

    always @(negedge clk) begin
        if (bus_if.mem_req && bus_if.mem_ready)
            log_q.push_back({bus_if.mem_we, bus_if.mem_addr,
                             bus_if.mem_we ? bus_if.mem_wdata : bus_if.mem_rdata});
        if (bus_if.mem_req) req_cnt <= req_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (bus_if.mem_req && hold_prev &&
            (prev_txn != {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata}))
            unstable_cnt <= unstable_cnt + 1;
        hold_prev <= bus_if.mem_req && !bus_if.mem_ready;
        prev_txn  <= {bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata};
    end

    int   n_pass  = 0;
    int   n_total = 0;
    txn_t exp_q[$];
    int   rd_idx  = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int nw);
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({1'b0, s + 32'(4 * i), src_word(s + 32'(4 * i))});
            exp_q.push_back({1'b1, d + 32'(4 * i), src_word(s + 32'(4 * i))});
        end
    endtask

    // Pop every expected transaction and compare it against the next logged one.
    task automatic check_log(input string tag);
        txn_t e;
        int   n_exp;
        n_exp = exp_q.size();
        chk({tag, "_count"}, 72'(log_q.size() - rd_idx), 72'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            e = exp_q.pop_front();
            if (rd_idx < log_q.size()) begin
                chk($sformatf("%s_txn%0d", tag, i), 72'(log_q[rd_idx]), 72'(e));
                rd_idx++;
            end
        end
        rd_idx = log_q.size();
    endtask

    // Pulse start; k=1 is the first cycle after the start edge.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                            input int max_k, output int done_k, output int done_n,
                            output int req_low_k, output logic req_k1);
        @(negedge clk);
        i_src_addr = s;
        i_dst_addr = d;
        i_length   = len;
        i_start    = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        done_k    = 0;
        done_n    = 0;
        req_low_k = 0;
        req_k1    = bus_if.mem_req;
        for (int k = 1; k <= max_k; k++) begin
            if (k > 1) @(negedge clk);
            if (o_done) begin
                if (done_n == 0) done_k = k;
                done_n++;
            end
            if (!bus_if.mem_req && req_low_k == 0) req_low_k = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   done_k, done_n, req_low_k, req0, dn0, un0, bound;
        logic req_k1, seen;

        resn = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_src_addr = '0; i_dst_addr = '0; i_length = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  72'(o_busy), 72'(0));
        chk("rst_done",  72'(o_done), 72'(0));
        chk("rst_error", 72'(o_error), 72'(0));
        chk("rst_words", 72'(o_words_done), 72'(0));
        chk("rst_req",   72'(bus_if.mem_req), 72'(0));
        chk("rst_addr",  72'(bus_if.mem_addr), 72'(0));
        chk("rst_we",    72'(bus_if.mem_we), 72'(0));
        chk("rst_wdata", 72'(bus_if.mem_wdata), 72'(0));
        chk("rst_be",    72'(bus_if.mem_be), 72'(4'hF));
        resn = 1'b1;

        // 4 words, zero-latency slave
        sl_lat = 0;
        push_copy(32'h100, 32'h200, 4);
        run_copy(32'h100, 32'h200, 16'd4, 30, done_k, done_n, req_low_k, req_k1);
        chk("t1_req_k1",  72'(req_k1), 72'(1));
        chk("t1_done_k",  72'(done_k), 72'(9));
        chk("t1_done_n",  72'(done_n), 72'(1));
        check_log("t1");
        chk("t1_words",   72'(o_words_done), 72'(2'd0) + 72'(4));
        chk("t1_error",   72'(o_error), 72'(0));
        chk("t1_busy",    72'(o_busy), 72'(0));

        // 2 words, latency 3: 4 request cycles per transaction, stable fields
        sl_lat = 3;
        req0 = req_cnt; un0 = unstable_cnt;
        push_copy(32'h300, 32'h400, 2);
        run_copy(32'h300, 32'h400, 16'd2, 30, done_k, done_n, req_low_k, req_k1);
        chk("t2_req_cycles", 72'(req_cnt - req0), 72'(16));
        chk("t2_unstable",   72'(unstable_cnt - un0), 72'(0));
        chk("t2_done_k",     72'(done_k), 72'(17));
        check_log("t2");
        chk("t2_words",      72'(o_words_done), 72'(2));
        chk("t2_error",      72'(o_error), 72'(0));

        // length 0: no bus access, done next cycle, no error
        sl_lat = 0;
        req0 = req_cnt;
        run_copy(32'h100, 32'h200, 16'd0, 6, done_k, done_n, req_low_k, req_k1);
        chk("t3_req",    72'(req_cnt - req0), 72'(0));
        chk("t3_done_k", 72'(done_k), 72'(1));
        chk("t3_done_n", 72'(done_n), 72'(1));
        chk("t3_error",  72'(o_error), 72'(0));

        // misaligned source: no bus access, done next cycle, error
        req0 = req_cnt;
        run_copy(32'h102, 32'h200, 16'd3, 6, done_k, done_n, req_low_k, req_k1);
        chk("t4_req",    72'(req_cnt - req0), 72'(0));
        chk("t4_done_k", 72'(done_k), 72'(1));
        chk("t4_error",  72'(o_error), 72'(1));
        chk("t4_words",  72'(o_words_done), 72'(0));

        // slave never ready: timeout after 8 request cycles
        sl_lat = 1000;
        req0 = req_cnt;
        run_copy(32'h100, 32'h200, 16'd3, 20, done_k, done_n, req_low_k, req_k1);
        chk("t5_req_cycles", 72'(req_cnt - req0), 72'(8));
        chk("t5_req_low_k",  72'(req_low_k), 72'(9));
        chk("t5_done_n",     72'(done_n), 72'(1));
        chk("t5_error",      72'(o_error), 72'(1));
        chk("t5_words",      72'(o_words_done), 72'(0));
        check_log("t5");

        // abort during read of word 2 of 5
        sl_lat = 2;
        exp_q.push_back({1'b0, 32'h500, src_word(32'h500)});
        exp_q.push_back({1'b1, 32'h600, src_word(32'h500)});
        exp_q.push_back({1'b0, 32'h504, src_word(32'h504)});
        dn0 = done_cnt;
        @(negedge clk);
        i_src_addr = 32'h500; i_dst_addr = 32'h600; i_length = 16'd5; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen = 1'b0; bound = 0;
        while (!seen && bound < 50) begin
            if (bus_if.mem_req && !bus_if.mem_we && bus_if.mem_addr == 32'h504) begin
                seen = 1'b1;
                i_abort = 1'b1;
            end else begin
                @(negedge clk);
                bound++;
            end
        end
        chk("t6_read2_seen", 72'(seen), 72'(1));
        repeat (20) @(negedge clk);
        i_abort = 1'b0;
        chk("t6_done_n", 72'(done_cnt - dn0), 72'(1));
        chk("t6_words",  72'(o_words_done), 72'(1));
        chk("t6_error",  72'(o_error), 72'(1));
        check_log("t6");

        // reset in the middle of a write, then a clean copy
        sl_lat = 3;
        @(negedge clk);
        i_src_addr = 32'h700; i_dst_addr = 32'h800; i_length = 16'd4; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen = 1'b0; bound = 0;
        while (!seen && bound < 50) begin
            if (bus_if.mem_req && bus_if.mem_we) seen = 1'b1;
            else begin
                @(negedge clk);
                bound++;
            end
        end
        chk("t7_write_seen", 72'(seen), 72'(1));
        dn0 = done_cnt;
        resn = 1'b0;
        @(negedge clk);
        chk("t7_req_after_rst",  72'(bus_if.mem_req), 72'(0));
        chk("t7_busy_after_rst", 72'(o_busy), 72'(0));
        chk("t7_done_after_rst", 72'(o_done), 72'(0));
        repeat (3) @(negedge clk);
        resn = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_no_done",  72'(done_cnt - dn0), 72'(0));
        chk("t7_words_rst", 72'(o_words_done), 72'(0));
        rd_idx = log_q.size();

        sl_lat = 0;
        push_copy(32'hA00, 32'hB00, 2);
        run_copy(32'hA00, 32'hB00, 16'd2, 20, done_k, done_n, req_low_k, req_k1);
        chk("t8_done_k", 72'(done_k), 72'(5));
        chk("t8_done_n", 72'(done_n), 72'(1));
        check_log("t8");
        chk("t8_words",  72'(o_words_done), 72'(2));
        chk("t8_error",  72'(o_error), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
